// File: rtl/mem_stage_port_pkg.sv
// Shared types and helpers for the MEM-stage memory port.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
// Contents: FSM state enum, load/store funct3 encodings (rv32i set plus ld/lwu/sd),
//   byte-size mask helper, funct3 legality check for a given bus width.
package mem_stage_port_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HELD = 2'd2
   } mem_port_state_t;

   typedef enum logic [2:0] {
      F3_LB  = 3'b000,
      F3_LH  = 3'b001,
      F3_LW  = 3'b010,
      F3_LD  = 3'b011,
      F3_LBU = 3'b100,
      F3_LHU = 3'b101,
      F3_LWU = 3'b110
   } load_funct3_t;

   typedef enum logic [2:0] {
      F3_SB = 3'b000,
      F3_SH = 3'b001,
      F3_SW = 3'b010,
      F3_SD = 3'b011
   } store_funct3_t;

   // Byte-lane mask for an access size code (funct3[1:0]), before lane shifting.
   function automatic logic [7:0] size_mask(input logic [1:0] sz);
      case (sz)
         2'b00:   return 8'h01;
         2'b01:   return 8'h03;
         2'b10:   return 8'h0F;
         default: return 8'hFF;
      endcase
   endfunction

   // True when funct3 names an access the bus width can carry.
   // 64-bit-only sizes (ld/lwu/sd) are rejected on a 32-bit bus.
   function automatic logic funct3_legal(input logic [2:0] f3, input logic is_store,
                                         input int dw);
      if (is_store) begin
         if (f3 == F3_SD) return (dw == 64);
         return (f3[2] == 1'b0);
      end
      case (f3)
         F3_LD, F3_LWU: return (dw == 64);
         3'b111:        return 1'b0;
         default:       return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane alignment for the MEM-stage port: store shift/byte enables, load extract, misalign detect.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs in the same cycle.
// Ports: funct3/is_write select size and direction; offset is addr[2:0];
//   store_data/mem_rdata in, byte_en/wdata/load_ext out; legal and misaligned flags.
module mem_lane_align
   import mem_stage_port_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [2:0]              funct3,
   input  logic                    is_write,
   input  logic [2:0]              offset,
   input  logic [DATA_WIDTH-1:0]   store_data,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic                    legal,
   output logic                    misaligned,
   output logic [DATA_WIDTH/8-1:0] byte_en,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH-1:0]   load_ext
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;
   localparam int OFF_W    = $clog2(BE_WIDTH);

   logic [OFF_W-1:0]      lane;
   logic [7:0]            mask8;
   logic [DATA_WIDTH-1:0] shifted;

   assign lane    = offset[OFF_W-1:0];
   assign mask8   = size_mask(funct3[1:0]);
   assign legal   = funct3_legal(funct3, is_write, DATA_WIDTH);
   assign byte_en = mask8[BE_WIDTH-1:0] << lane;
   assign wdata   = store_data << {lane, 3'b000};
   assign shifted = mem_rdata >> {lane, 3'b000};

   // Natural alignment: offset must be a multiple of the access size.
   always_comb begin
      misaligned = 1'b0;
      case (funct3[1:0])
         2'b01:   misaligned = offset[0];
         2'b10:   misaligned = (offset[1:0] != 2'b00);
         2'b11:   misaligned = (offset != 3'b000);
         default: misaligned = 1'b0;
      endcase
   end

   always_comb begin
      load_ext = shifted;
      case (funct3)
         F3_LB:   load_ext = DATA_WIDTH'($signed(shifted[7:0]));
         F3_LH:   load_ext = DATA_WIDTH'($signed(shifted[15:0]));
         F3_LW:   load_ext = DATA_WIDTH'($signed(shifted[31:0]));
         F3_LBU:  load_ext = DATA_WIDTH'(shifted[7:0]);
         F3_LHU:  load_ext = DATA_WIDTH'(shifted[15:0]);
         F3_LWU:  load_ext = DATA_WIDTH'(shifted[31:0]);
         default: load_ext = shifted;
      endcase
   end

endmodule

// File: rtl/mem_stage_port.sv
// MEM-stage memory port: issues one access per op, holds it until mem_resp, stalls meanwhile.
// Latency: strobe in the op's first cycle; load result valid in the mem_resp cycle, then held.
// Backpressure: busy stalls the pipeline until mem_resp; result held in HELD until advance.
// Ports: clk/rst_n (sync, active-low); op_read/op_write/funct3/addr/store_data from the MEM
//   stage; advance from global stall logic; mem_* to/from memory; busy, load_data, misaligned
//   and perf_stall_cnt/perf_access_cnt back to the core.
// Optional: define MEM_STAGE_PORT_PERF_EN to build the counters; otherwise they read 0.
module mem_stage_port
   import mem_stage_port_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    op_read,
   input  logic                    op_write,
   input  logic [2:0]              funct3,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [DATA_WIDTH-1:0]   store_data,
   input  logic                    advance,
   input  logic                    mem_resp,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic                    mem_read,
   output logic                    mem_write,
   output logic [ADDR_WIDTH-1:0]   mem_address,
   output logic [DATA_WIDTH/8-1:0] mem_byte_en,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic                    busy,
   output logic [DATA_WIDTH-1:0]   load_data,
   output logic                    misaligned,
   output logic [31:0]             perf_stall_cnt,
   output logic [31:0]             perf_access_cnt
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;
   localparam int OFF_W    = $clog2(BE_WIDTH);

   mem_port_state_t       state;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic                  req, legal, mis_raw, not_held, op, resp_ok;
   logic [BE_WIDTH-1:0]   be_lane;
   logic [DATA_WIDTH-1:0] wdata_lane, load_ext;

   mem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
      .funct3     (funct3),
      .is_write   (op_write),
      .offset     (addr[2:0]),
      .store_data (store_data),
      .mem_rdata  (mem_rdata),
      .legal      (legal),
      .misaligned (mis_raw),
      .byte_en    (be_lane),
      .wdata      (wdata_lane),
      .load_ext   (load_ext)
   );

   // HELD means the current MEM op already completed; nothing is reissued
   // and a stray mem_resp is ignored until the pipeline advances.
   assign req      = op_read | op_write;
   assign not_held = (state != HELD);
   assign op       = req & legal & ~mis_raw & not_held;
   assign resp_ok  = op & mem_resp;

   assign misaligned  = req & legal & mis_raw & not_held;
   assign mem_read    = op & op_read;
   assign mem_write   = op & op_write;
   assign mem_address = op ? {addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}} : '0;
   assign mem_byte_en = (op & op_write) ? be_lane : '0;
   assign mem_wdata   = (op & op_write) ? wdata_lane : '0;
   assign busy        = op & ~mem_resp;

   // Response data passes straight through in its cycle so the response cycle never stalls.
   assign load_data = misaligned           ? '0       :
                      (resp_ok & op_read)  ? load_ext : rdata_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         rdata_q <= '0;
      end else begin
         if (resp_ok && op_read) rdata_q <= load_ext;
         case (state)
            IDLE: if (op) state <= mem_resp ? (advance ? IDLE : HELD) : WAIT;
            // op only vanishes here if the stage was flushed; do not strand the FSM.
            WAIT: if (!op)          state <= IDLE;
                  else if (mem_resp) state <= advance ? IDLE : HELD;
            HELD: if (advance)       state <= IDLE;
            default:                 state <= IDLE;
         endcase
      end
   end

`ifdef MEM_STAGE_PORT_PERF_EN
   logic [31:0] stall_q, access_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_q  <= '0;
         access_q <= '0;
      end else begin
         if (busy)    stall_q  <= stall_q + 32'd1;
         if (resp_ok) access_q <= access_q + 32'd1;
      end
   end

   assign perf_stall_cnt  = stall_q;
   assign perf_access_cnt = access_q;
`else
   assign perf_stall_cnt  = '0;
   assign perf_access_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_stage_port.sv
module tb_mem_stage_port;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        rd = 0, wr = 0, adv = 0, rsp = 0, cmp_en = 0;
   logic [2:0]  f3 = 0;
   logic [31:0] ad = 0;
   logic [63:0] sd = 0, rdat = 0;
   int          checks = 0, errors = 0;

   logic        r32, w32, b32, m32, r64, w64, b64, m64;
   logic [31:0] a32, wd32, ld32, ps32, pa32, a64, ps64, pa64;
   logic [3:0]  be32;
   logic [7:0]  be64;
   logic [63:0] wd64, ld64;

   // Abstract model state per port (index 0: 32-bit bus, 1: 64-bit bus).
   logic        done [2] = '{1'b0, 1'b0};
   logic [63:0] rq   [2] = '{64'd0, 64'd0};
   logic [31:0] stl  [2] = '{32'd0, 32'd0};
   logic [31:0] acc  [2] = '{32'd0, 32'd0};

   always #5 clk = ~clk;

   mem_stage_port #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) u32 (
      .clk(clk), .rst_n(rst_n), .op_read(rd), .op_write(wr), .funct3(f3), .addr(ad),
      .store_data(sd[31:0]), .advance(adv), .mem_resp(rsp), .mem_rdata(rdat[31:0]),
      .mem_read(r32), .mem_write(w32), .mem_address(a32), .mem_byte_en(be32),
      .mem_wdata(wd32), .busy(b32), .load_data(ld32), .misaligned(m32),
      .perf_stall_cnt(ps32), .perf_access_cnt(pa32));

   mem_stage_port #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) u64 (
      .clk(clk), .rst_n(rst_n), .op_read(rd), .op_write(wr), .funct3(f3), .addr(ad),
      .store_data(sd), .advance(adv), .mem_resp(rsp), .mem_rdata(rdat),
      .mem_read(r64), .mem_write(w64), .mem_address(a64), .mem_byte_en(be64),
      .mem_wdata(wd64), .busy(b64), .load_data(ld64), .misaligned(m64),
      .perf_stall_cnt(ps64), .perf_access_cnt(pa64));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Take bytes [off, off+size) of the bus word, extend per signedness.
   function automatic logic [63:0] m_ext(input logic [2:0] f, input logic [63:0] v0,
                                         input int off);
      int bits;
      logic [63:0] v, lowm;
      bits = 8 << f[1:0];
      v = v0 >> (8 * off);
      if (bits < 64) begin
         lowm = (64'd1 << bits) - 64'd1;
         v = v & lowm;
         if (!f[2] && v[bits-1]) v = v | ~lowm;
      end
      return v;
   endfunction

   task automatic model_now(input int k, input int dw, output logic e_act, e_rd, e_wr,
                            e_mis, e_busy, output logic [63:0] e_addr, e_be, e_wd, e_ld,
                            e_ext);
      int nb, off;
      logic leg, bad;
      logic [63:0] dm;
      dm  = (dw == 64) ? '1 : 64'hFFFF_FFFF;
      nb  = 1 << f3[1:0];
      off = int'(ad % (dw / 8));
      if (wr) leg = (f3 < 3) || (f3 == 3 && dw == 64);
      else    leg = (f3 != 7) && (dw == 64 || (f3 != 3 && f3 != 6));
      bad    = (ad % nb) != 0;
      e_mis  = (rd | wr) & leg & bad & ~done[k];
      e_act  = (rd | wr) & leg & ~bad & ~done[k];
      e_rd   = e_act & rd;
      e_wr   = e_act & wr;
      e_busy = e_act & ~rsp;
      e_addr = e_act ? 64'(ad - (ad % (dw / 8))) : 64'd0;
      e_be   = e_wr ? ((64'd1 << nb) - 64'd1) << off : 64'd0;
      e_wd   = e_wr ? (sd << (8 * off)) & dm : 64'd0;
      e_ext  = m_ext(f3, rdat & dm, off) & dm;
      e_ld   = e_mis ? 64'd0 : (e_act & rd & rsp) ? e_ext : rq[k];
   endtask

   always @(posedge clk) begin
      logic ea, er, ew, em, eb;
      logic [63:0] eadr, ebe, ewd, eld, eext;
      for (int k = 0; k < 2; k++) begin
         model_now(k, (k == 1) ? 64 : 32, ea, er, ew, em, eb, eadr, ebe, ewd, eld, eext);
         if (!rst_n) begin
            done[k] = 1'b0; rq[k] = 64'd0; stl[k] = 32'd0; acc[k] = 32'd0;
         end else begin
            if (eb) stl[k] = stl[k] + 32'd1;
            if (ea && rsp) begin
               acc[k] = acc[k] + 32'd1;
               if (rd) rq[k] = eext;
               done[k] = !adv;
            end else if (done[k] && adv) begin
               done[k] = 1'b0;
            end
         end
      end
   end

   task automatic cmp_one(input int k, input int dw, input logic r, w, m, b,
                          input logic [63:0] a, be, wd, ld, input logic [31:0] ps, pa);
      logic ea, er, ew, em, eb;
      logic [63:0] eadr, ebe, ewd, eld, eext;
      string p;
      p = $sformatf("u%0d.", dw);
      model_now(k, dw, ea, er, ew, em, eb, eadr, ebe, ewd, eld, eext);
      chk({p, "mem_read"}, 64'(r), 64'(er));
      chk({p, "mem_write"}, 64'(w), 64'(ew));
      chk({p, "misaligned"}, 64'(m), 64'(em));
      chk({p, "busy"}, 64'(b), 64'(eb));
      chk({p, "mem_address"}, a, eadr);
      chk({p, "mem_byte_en"}, be, ebe);
      chk({p, "mem_wdata"}, wd, ewd);
      chk({p, "load_data"}, ld, eld);
`ifdef MEM_STAGE_PORT_PERF_EN
      chk({p, "perf_stall_cnt"}, 64'(ps), 64'(stl[k]));
      chk({p, "perf_access_cnt"}, 64'(pa), 64'(acc[k]));
`else
      chk({p, "perf_stall_cnt"}, 64'(ps), 64'd0);
      chk({p, "perf_access_cnt"}, 64'(pa), 64'd0);
`endif
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         cmp_one(0, 32, r32, w32, m32, b32, 64'(a32), 64'(be32), 64'(wd32), 64'(ld32),
                 ps32, pa32);
         cmp_one(1, 64, r64, w64, m64, b64, 64'(a64), 64'(be64), wd64, ld64, ps64, pa64);
      end
   end

   task automatic drv(input logic r, w, input logic [2:0] f, input logic [31:0] a,
                      input logic [63:0] s, input logic av, rs, input logic [63:0] rdv);
      rd = r; wr = w; f3 = f; ad = a; sd = s; adv = av; rsp = rs; rdat = rdv;
   endtask

   task automatic smp;
      @(negedge clk);
   endtask

   task automatic nxt;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int nw, nbz;
      drv(0, 0, 3'd0, 32'd0, 64'd0, 0, 0, 64'd0);
      rst_n = 1'b0;
      nxt; nxt;
      rst_n = 1'b1;
      cmp_en = 1'b1;
      smp;
      chk("rst.load_data", 64'(ld32), 64'd0);
      chk("rst.busy", 64'(b32), 64'd0);
      chk("rst.mem_read", 64'(r32), 64'd0);
      chk("rst.perf_stall", 64'(ps64), 64'd0);
      nxt;

      // 1: sw, response on the fourth cycle
      drv(0, 1, 3'b010, 32'h104, 64'hDEAD_BEEF, 1, 0, 64'd0);
      nw = 0; nbz = 0;
      for (int i = 0; i < 4; i++) begin
         rsp = (i == 3);
         smp;
         nw += int'(w32); nbz += int'(b32);
         chk("t1.byte_en", 64'(be32), 64'hF);
         chk("t1.address", 64'(a32), 64'h104);
         nxt;
      end
      chk("t1.write_cycles", 64'(nw), 64'd4);
      chk("t1.busy_cycles", 64'(nbz), 64'd3);

      // 2: lb, same-cycle response
      drv(1, 0, 3'b000, 32'h103, 64'd0, 1, 1, 64'h8000_0000);
      smp;
      chk("t2.load_data", 64'(ld32), 64'hFFFF_FF80);
      chk("t2.busy", 64'(b32), 64'd0);
      chk("t2.mem_read", 64'(r32), 64'd1);
      nxt;
      drv(0, 0, 3'd0, 32'd0, 64'd0, 1, 0, 64'd0);
      smp;
      chk("t2.hold", 64'(ld32), 64'hFFFF_FF80);
      nxt;

      // 3: lhu answered while frozen, then held two cycles (stray resp in HELD)
      drv(1, 0, 3'b101, 32'h102, 64'd0, 0, 1, 64'hABCD_0000);
      smp;
      chk("t3.load_data", 64'(ld32), 64'h0000_ABCD);
      chk("t3.busy", 64'(b32), 64'd0);
      nxt;
      rsp = 1; rdat = 64'h1234_5678;
      smp;
      chk("t3.held_read", 64'(r32), 64'd0);
      chk("t3.held_data", 64'(ld32), 64'h0000_ABCD);
      chk("t3.held_busy", 64'(b32), 64'd0);
      nxt;
      rsp = 0; adv = 1;
      smp;
      chk("t3.held_read2", 64'(r32), 64'd0);
      chk("t3.held_data2", 64'(ld32), 64'h0000_ABCD);
      nxt;

      // 4: misaligned lw
      drv(1, 0, 3'b010, 32'h102, 64'd0, 1, 0, 64'd0);
      smp;
      chk("t4.misaligned", 64'(m32), 64'd1);
      chk("t4.mem_read", 64'(r32), 64'd0);
      chk("t4.busy", 64'(b32), 64'd0);
      chk("t4.load_data", 64'(ld32), 64'd0);
      chk("t4.misaligned64", 64'(m64), 64'd1);
      nxt;

      // Directed sweep: every load encoding at every lane, then every store size.
      for (int f = 0; f < 8; f++) begin
         for (int o = 0; o < 8; o++) begin
            drv(1, 0, 3'(f), 32'h300 + 32'(o), 64'd0, 1, 1, 64'h8877_6655_F4E3_D2C1);
            smp;
            if (f == 1 && o == 2) chk("sweep.lh_off2", 64'(ld32), 64'hFFFF_F4E3);
            if (f == 6 && o == 4) chk("sweep.lwu64_off4", ld64, 64'h0000_0000_8877_6655);
            nxt;
         end
      end
      for (int f = 0; f < 4; f++) begin
         for (int o = 0; o < 8; o++) begin
            drv(0, 1, 3'(f), 32'h300 + 32'(o), 64'h1122_3344_5566_7788, 1, 1, 64'd0);
            smp;
            if (f == 1 && o == 2) begin
               chk("sweep.sh_be", 64'(be32), 64'hC);
               chk("sweep.sh_wdata", 64'(wd32), 64'h7788_0000);
            end
            nxt;
         end
      end

      // 5: reset while waiting; stray response afterwards
      drv(1, 0, 3'b010, 32'h200, 64'd0, 0, 0, 64'd0);
      smp;
      chk("t5.busy_issue", 64'(b32), 64'd1);
      nxt;
      rst_n = 1'b0;
      smp;
      chk("t5.wait_read", 64'(r32), 64'd1);
      nxt;
      rst_n = 1'b1;
      drv(0, 0, 3'b010, 32'h200, 64'd0, 0, 1, 64'hFFFF_FFFF);
      smp;
      chk("t5.read_dropped", 64'(r32), 64'd0);
      chk("t5.busy", 64'(b32), 64'd0);
      chk("t5.load_data", 64'(ld32), 64'd0);
      nxt;
      rsp = 0;
      smp;
      chk("t5.stray_ignored", 64'(ld32), 64'd0);
      nxt;

      // 6: sd on the 64-bit port, response on the third cycle
      drv(0, 1, 3'b011, 32'h1008, 64'h0123_4567_89AB_CDEF, 1, 0, 64'd0);
      for (int i = 0; i < 3; i++) begin
         rsp = (i == 2);
         smp;
         chk("t6.byte_en64", 64'(be64), 64'hFF);
         chk("t6.write32_none", 64'(w32), 64'd0);
         chk("t6.misaligned32", 64'(m32), 64'd0);
         nxt;
      end
      drv(0, 0, 3'd0, 32'd0, 64'd0, 1, 0, 64'd0);
      smp;
`ifdef MEM_STAGE_PORT_PERF_EN
      chk("t6.perf_stall", 64'(ps64), 64'd2);
      chk("t6.perf_access", 64'(pa64), 64'd1);
`else
      chk("t6.perf_stall", 64'(ps64), 64'd0);
      chk("t6.perf_access", 64'(pa64), 64'd0);
`endif
      nxt;
      smp;
      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
